// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler slice: op bit indices, widths and grant source encoding.
package alu_sched_pkg;

  localparam int ALU_OP_W  = 13;
  localparam int ALU_TAG_W = 4;

  // One-hot op vector bit positions, add is the MSB
  localparam int ALU_OP_ADD   = 12;
  localparam int ALU_OP_SUB   = 11;
  localparam int ALU_OP_SLL   = 10;
  localparam int ALU_OP_SLT   = 9;
  localparam int ALU_OP_SLTU  = 8;
  localparam int ALU_OP_XOR   = 7;
  localparam int ALU_OP_SRL   = 6;
  localparam int ALU_OP_SRA   = 5;
  localparam int ALU_OP_OR    = 4;
  localparam int ALU_OP_AND   = 3;
  localparam int ALU_OP_LUI   = 2;
  localparam int ALU_OP_AUIPC = 1;
  localparam int ALU_OP_JUMP  = 0;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/exu_alu.sv
// Combinational integer ALU. Multiple op bits resolve by priority, add highest, jump lowest.
module exu_alu
  import alu_sched_pkg::*;
(
  input  logic                rst,
  input  logic                int_assert_i,
  input  logic                req_alu_i,
  input  logic                jump_i,
  input  logic [31:0]         alu_op1_i,
  input  logic [31:0]         alu_op2_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [4:0]          rd_i,
  output logic [31:0]         result_o,
  output logic                reg_we_o,
  output logic [4:0]          rd_o
);

  logic [4:0] shamt_s;
  assign shamt_s = alu_op2_i[4:0];

  // Result select and write enable
  always_comb begin
    result_o = 32'd0;
    reg_we_o = 1'b0;
    rd_o     = 5'd0;
    if (rst || int_assert_i) begin
      result_o = 32'd0;
    end else begin
      rd_o     = rd_i;
      reg_we_o = (req_alu_i || jump_i) && (rd_i != 5'd0);
      if (alu_op_i[ALU_OP_ADD]) begin
        result_o = alu_op1_i + alu_op2_i;
      end else if (alu_op_i[ALU_OP_SUB]) begin
        result_o = alu_op1_i - alu_op2_i;
      end else if (alu_op_i[ALU_OP_SLL]) begin
        result_o = alu_op1_i << shamt_s;
      end else if (alu_op_i[ALU_OP_SLT]) begin
        result_o = {31'd0, ($signed(alu_op1_i) < $signed(alu_op2_i))};
      end else if (alu_op_i[ALU_OP_SLTU]) begin
        result_o = {31'd0, (alu_op1_i < alu_op2_i)};
      end else if (alu_op_i[ALU_OP_XOR]) begin
        result_o = alu_op1_i ^ alu_op2_i;
      end else if (alu_op_i[ALU_OP_SRL]) begin
        result_o = alu_op1_i >> shamt_s;
      end else if (alu_op_i[ALU_OP_SRA]) begin
        result_o = $unsigned($signed(alu_op1_i) >>> shamt_s);
      end else if (alu_op_i[ALU_OP_OR]) begin
        result_o = alu_op1_i | alu_op2_i;
      end else if (alu_op_i[ALU_OP_AND]) begin
        result_o = alu_op1_i & alu_op2_i;
      end else if (alu_op_i[ALU_OP_LUI]) begin
        result_o = alu_op2_i;
      end else if (alu_op_i[ALU_OP_AUIPC] || alu_op_i[ALU_OP_JUMP]) begin
        // jump writes the link address op1+op2 (pc + 4)
        result_o = alu_op1_i + alu_op2_i;
      end else begin
        result_o = 32'd0;
      end
    end
  end

endmodule

// File: rtl/exu_alu_sched_chk.sv
// Simulation checks for the ALU scheduler: legal one-hot ops and ready only alongside valid.
module exu_alu_sched_chk #(
  parameter int OP_W = 13
) (
  input logic            clk,
  input logic            rst,
  input logic            grant,
  input logic            req0_valid,
  input logic            req1_valid,
  input logic            req0_ready,
  input logic            req1_ready,
  input logic [OP_W-1:0] op
);

  a_op_onehot: assert property (@(posedge clk) disable iff (rst) grant |-> $onehot0(op));
  a_ready0_valid: assert property (@(posedge clk) disable iff (rst) req0_ready |-> req0_valid);
  a_ready1_valid: assert property (@(posedge clk) disable iff (rst) req1_ready |-> req1_valid);
  a_single_grant: assert property (@(posedge clk) disable iff (rst) !(req0_ready && req1_ready));

endmodule

// File: rtl/exu_alu_sched.sv
// Two-requester scheduler for the shared exu_alu with a registered writeback stage.
// Optional round-robin arbitration: define ALIOTH_ALU_SCHED_RR_EN (default is fixed req0 priority).
module exu_alu_sched
  import alu_sched_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_assert_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_op1_i,
  input  logic [31:0]      req0_op2_i,
  input  logic [OP_W-1:0]  req0_op_i,
  input  logic [4:0]       req0_rd_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_op1_i,
  input  logic [31:0]      req1_op2_i,
  input  logic [OP_W-1:0]  req1_op_i,
  input  logic [4:0]       req1_rd_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic             wb_we_o,
  output logic [4:0]       wb_rd_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_src_o,
  output logic             busy_o
);

  logic             can_acc_s;
  logic             grant_s;
  logic             sel1_s;
  logic [31:0]      op1_s;
  logic [31:0]      op2_s;
  logic [OP_W-1:0]  op_s;
  logic [4:0]       rd_s;
  logic [TAG_W-1:0] tag_s;
  logic             req_alu_s;
  logic             jump_s;
  logic [31:0]      alu_result_s;
  logic             alu_we_s;
  logic [4:0]       alu_rd_s;

  logic             wb_valid_r;
  logic [31:0]      wb_result_r;
  logic             wb_we_r;
  logic [4:0]       wb_rd_r;
  logic [TAG_W-1:0] wb_tag_r;
  logic             wb_src_r;

  // Accept when the stage is empty or draining this cycle
  assign can_acc_s = ~wb_valid_r | wb_ready_i;
  assign grant_s   = can_acc_s & ~int_assert_i & (req0_valid_i | req1_valid_i);

`ifdef ALIOTH_ALU_SCHED_RR_EN
  logic ptr_r;

  // Round-robin pointer flips to the other requester after each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (grant_s) begin
      ptr_r <= ~sel1_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Requester select: pointer side wins on contention
  always_comb begin
    sel1_s = req1_valid_i & (~req0_valid_i | ptr_r);
  end
`else
  // Requester select: req0 has fixed priority
  always_comb begin
    sel1_s = req1_valid_i & ~req0_valid_i;
  end
`endif

  assign req0_ready_o = grant_s & ~sel1_s;
  assign req1_ready_o = grant_s & sel1_s;

  // Operand mux into the shared ALU
  always_comb begin
    op1_s = req0_op1_i;
    op2_s = req0_op2_i;
    op_s  = req0_op_i;
    rd_s  = req0_rd_i;
    tag_s = req0_tag_i;
    if (sel1_s) begin
      op1_s = req1_op1_i;
      op2_s = req1_op2_i;
      op_s  = req1_op_i;
      rd_s  = req1_rd_i;
      tag_s = req1_tag_i;
    end else begin
      op1_s = req0_op1_i;
      op2_s = req0_op2_i;
      op_s  = req0_op_i;
      rd_s  = req0_rd_i;
      tag_s = req0_tag_i;
    end
  end

  assign req_alu_s = |op_s[OP_W-1:1];
  assign jump_s    = op_s[0];

  exu_alu u_exu_alu (
    .rst          (rst),
    .int_assert_i (1'b0),
    .req_alu_i    (req_alu_s),
    .jump_i       (jump_s),
    .alu_op1_i    (op1_s),
    .alu_op2_i    (op2_s),
    .alu_op_i     (op_s),
    .rd_i         (rd_s),
    .result_o     (alu_result_s),
    .reg_we_o     (alu_we_s),
    .rd_o         (alu_rd_s)
  );

  // Output stage: flush beats grant, grant beats drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      wb_result_r <= 32'd0;
      wb_we_r     <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_tag_r    <= '0;
      wb_src_r    <= SRC_REQ0;
    end else if (int_assert_i) begin
      wb_valid_r  <= 1'b0;
    end else if (grant_s) begin
      wb_valid_r  <= 1'b1;
      wb_result_r <= alu_result_s;
      wb_we_r     <= alu_we_s;
      wb_rd_r     <= alu_rd_s;
      wb_tag_r    <= tag_s;
      wb_src_r    <= sel1_s ? SRC_REQ1 : SRC_REQ0;
    end else if (wb_ready_i) begin
      wb_valid_r  <= 1'b0;
    end else begin
      wb_valid_r  <= wb_valid_r;
    end
  end

  assign wb_valid_o  = wb_valid_r;
  assign wb_result_o = wb_result_r;
  assign wb_we_o     = wb_we_r;
  assign wb_rd_o     = wb_rd_r;
  assign wb_tag_o    = wb_tag_r;
  assign wb_src_o    = wb_src_r;
  assign busy_o      = wb_valid_r;

  exu_alu_sched_chk #(.OP_W(OP_W)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant_s),
    .req0_valid (req0_valid_i),
    .req1_valid (req1_valid_i),
    .req0_ready (req0_ready_o),
    .req1_ready (req1_ready_o),
    .op         (op_s)
  );

endmodule
